axi4lite_ocm_responder: RTL and testbench

- AXI4-Lite subordinate memory: the responder end of the PS master write_mem/read_mem traffic used in the MPSoC bring-up benches.
- Decodes a fixed address window, for example the 0xFFFC0000 OCM alias, onto a word-addressed RAM.
- Honours byte strobes and returns OKAY/SLVERR responses.
- Sits on an M_AXI_HPM port of the PS (via interconnect) so benches can check write/readback round trips and error paths.

---
 rtl/axi4lite_ocm_responder.sv | 203 ++++++++++++++++++++
 tb/tb_axi4lite_ocm_responder.sv | 356 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/axi4lite_ocm_responder.sv
// AXI4-Lite subordinate RAM decoding a fixed byte window onto a word-addressed array,
// with byte strobes, OKAY/SLVERR responses and saturating traffic counters.
module axi4lite_ocm_responder #(
    parameter int                    ADDR_WIDTH  = 32,
    parameter int                    DATA_WIDTH  = 32,
    parameter int                    DEPTH_WORDS = 1024,
    parameter logic [ADDR_WIDTH-1:0] BASE_ADDR   = 32'hFFFC0000
) (
    input  logic                    ACLK,
    input  logic                    ARESET,
    input  logic [ADDR_WIDTH-1:0]   S_AWADDR,
    input  logic                    S_AWVALID,
    output logic                    S_AWREADY,
    input  logic [DATA_WIDTH-1:0]   S_WDATA,
    input  logic [DATA_WIDTH/8-1:0] S_WSTRB,
    input  logic                    S_WVALID,
    output logic                    S_WREADY,
    output logic [1:0]              S_BRESP,
    output logic                    S_BVALID,
    input  logic                    S_BREADY,
    input  logic [ADDR_WIDTH-1:0]   S_ARADDR,
    input  logic                    S_ARVALID,
    output logic                    S_ARREADY,
    output logic [DATA_WIDTH-1:0]   S_RDATA,
    output logic [1:0]              S_RRESP,
    output logic                    S_RVALID,
    input  logic                    S_RREADY,
    output logic [15:0]             wr_count,
    output logic [15:0]             rd_count,
    output logic [15:0]             err_count
);
    localparam int IDX_W  = $clog2(DEPTH_WORDS);
    localparam int STRB_W = DATA_WIDTH / 8;
    localparam logic [ADDR_WIDTH:0] WIN_BYTES = (ADDR_WIDTH+1)'(DEPTH_WORDS * 4);
    localparam logic [1:0] OKAY   = 2'b00;
    localparam logic [1:0] SLVERR = 2'b10;

    typedef enum logic [1:0] {IDLE, HAVE_AW, HAVE_W, RESP} wr_state_t;

    function automatic logic [DATA_WIDTH-1:0] merge_bytes(input logic [DATA_WIDTH-1:0] old_w,
                                                          input logic [DATA_WIDTH-1:0] new_w,
                                                          input logic [STRB_W-1:0]     strb);
        logic [DATA_WIDTH-1:0] r;
        r = old_w;
        for (int i = 0; i < STRB_W; i++)
            if (strb[i]) r[8*i +: 8] = new_w[8*i +: 8];
        return r;
    endfunction

    function automatic logic [15:0] sat_add(input logic [15:0] cnt, input logic [1:0] inc);
        logic [16:0] s;
        s = {1'b0, cnt} + {15'b0, inc};
        return s[16] ? 16'hFFFF : s[15:0];
    endfunction

    logic [DATA_WIDTH-1:0] mem [DEPTH_WORDS] = '{default: '0};

    wr_state_t             state_q, state_d;
    logic                  awready_q, awready_d, wready_q, wready_d;
    logic                  bvalid_q, bvalid_d;
    logic [1:0]            bresp_q, bresp_d;
    logic [ADDR_WIDTH-1:0] awaddr_q, awaddr_d;
    logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
    logic [STRB_W-1:0]     wstrb_q, wstrb_d;
    logic                  rvalid_q, rvalid_d;
    logic [DATA_WIDTH-1:0] rdata_q, rdata_d;
    logic [1:0]            rresp_q, rresp_d;
    logic [15:0]           wr_count_q, wr_count_d, rd_count_q, rd_count_d, err_count_q, err_count_d;

    logic                  aw_hs, w_hs, ar_hs, b_hs, r_hs, arready;
    logic                  cm_en, cm_ok, ar_ok;
    logic [ADDR_WIDTH-1:0] cm_addr, cm_off, ar_off;
    logic [DATA_WIDTH-1:0] cm_data, rd_word;
    logic [STRB_W-1:0]     cm_strb;
    logic [IDX_W-1:0]      cm_idx, ar_idx;

    assign aw_hs   = S_AWVALID && awready_q;
    assign w_hs    = S_WVALID && wready_q;
    assign b_hs    = bvalid_q && S_BREADY;
    assign arready = !rvalid_q || S_RREADY;
    assign ar_hs   = S_ARVALID && arready;
    assign r_hs    = rvalid_q && S_RREADY;

    // The commit happens in the cycle the second of AW/W arrives, sourcing whichever half was held.
    always_comb begin
        state_d  = state_q;
        awaddr_d = awaddr_q;
        wdata_d  = wdata_q;
        wstrb_d  = wstrb_q;
        bresp_d  = bresp_q;
        cm_en    = 1'b0;
        cm_addr  = S_AWADDR;
        cm_data  = S_WDATA;
        cm_strb  = S_WSTRB;
        case (state_q)
            IDLE: begin
                if (aw_hs && w_hs) begin
                    cm_en   = 1'b1;
                    state_d = RESP;
                end else if (aw_hs) begin
                    awaddr_d = S_AWADDR;
                    state_d  = HAVE_AW;
                end else if (w_hs) begin
                    wdata_d = S_WDATA;
                    wstrb_d = S_WSTRB;
                    state_d = HAVE_W;
                end
            end
            HAVE_AW: if (w_hs) begin
                cm_en   = 1'b1;
                cm_addr = awaddr_q;
                state_d = RESP;
            end
            HAVE_W: if (aw_hs) begin
                cm_en   = 1'b1;
                cm_data = wdata_q;
                cm_strb = wstrb_q;
                state_d = RESP;
            end
            default: if (S_BREADY) state_d = IDLE;
        endcase
        cm_off = cm_addr - BASE_ADDR;
        cm_ok  = cm_en && ({1'b0, cm_off} < WIN_BYTES);
        cm_idx = cm_off[IDX_W+1:2];
        if (cm_en) bresp_d = cm_ok ? OKAY : SLVERR;
        awready_d = (state_d == IDLE) || (state_d == HAVE_W);
        wready_d  = (state_d == IDLE) || (state_d == HAVE_AW);
        bvalid_d  = (state_d == RESP);
    end

    // Reads see a same-cycle commit to the same word.
    always_comb begin
        ar_off  = S_ARADDR - BASE_ADDR;
        ar_ok   = {1'b0, ar_off} < WIN_BYTES;
        ar_idx  = ar_off[IDX_W+1:2];
        rd_word = mem[ar_idx];
        if (cm_ok && (cm_idx == ar_idx)) rd_word = merge_bytes(rd_word, cm_data, cm_strb);
        rvalid_d = rvalid_q;
        rdata_d  = rdata_q;
        rresp_d  = rresp_q;
        if (ar_hs) begin
            rvalid_d = 1'b1;
            rdata_d  = ar_ok ? rd_word : '0;
            rresp_d  = ar_ok ? OKAY : SLVERR;
        end else if (r_hs) begin
            rvalid_d = 1'b0;
        end
    end

    always_comb begin
        wr_count_d  = sat_add(wr_count_q, {1'b0, b_hs});
        rd_count_d  = sat_add(rd_count_q, {1'b0, r_hs});
        err_count_d = sat_add(err_count_q, {1'b0, b_hs && (bresp_q == SLVERR)} +
                                           {1'b0, r_hs && (rresp_q == SLVERR)});
    end

    always_ff @(posedge ACLK) begin
        if (ARESET) begin
            state_q     <= IDLE;
            awready_q   <= 1'b1;
            wready_q    <= 1'b1;
            bvalid_q    <= 1'b0;
            bresp_q     <= OKAY;
            rvalid_q    <= 1'b0;
            rdata_q     <= '0;
            rresp_q     <= OKAY;
            wr_count_q  <= '0;
            rd_count_q  <= '0;
            err_count_q <= '0;
        end else begin
            state_q     <= state_d;
            awready_q   <= awready_d;
            wready_q    <= wready_d;
            bvalid_q    <= bvalid_d;
            bresp_q     <= bresp_d;
            rvalid_q    <= rvalid_d;
            rdata_q     <= rdata_d;
            rresp_q     <= rresp_d;
            wr_count_q  <= wr_count_d;
            rd_count_q  <= rd_count_d;
            err_count_q <= err_count_d;
        end
    end

    always_ff @(posedge ACLK) begin
        awaddr_q <= awaddr_d;
        wdata_q  <= wdata_d;
        wstrb_q  <= wstrb_d;
        if (cm_ok && !ARESET) mem[cm_idx] <= merge_bytes(mem[cm_idx], cm_data, cm_strb);
    end

    assign S_AWREADY = awready_q;
    assign S_WREADY  = wready_q;
    assign S_BVALID  = bvalid_q;
    assign S_BRESP   = bresp_q;
    assign S_ARREADY = arready;
    assign S_RVALID  = rvalid_q;
    assign S_RDATA   = rdata_q;
    assign S_RRESP   = rresp_q;
    assign wr_count  = wr_count_q;
    assign rd_count  = rd_count_q;
    assign err_count = err_count_q;
endmodule

// File: tb/tb_axi4lite_ocm_responder.sv
// Bench for axi4lite_ocm_responder: directed vector table, multi-cycle corner sequences
// and randomized traffic against a word-array reference model.
module tb_axi4lite_ocm_responder;
    localparam logic [31:0] BASE   = 32'hFFFC0000;
    localparam longint      BASE_L = 64'h0000_0000_FFFC_0000;
    localparam int          DEPTH  = 1024;

    logic        clk = 1'b0;
    logic        ARESET = 1'b1;
    logic [31:0] AWADDR = '0, WDATA = '0, ARADDR = '0;
    logic [3:0]  WSTRB = '0;
    logic        AWVALID = 1'b0, WVALID = 1'b0, BREADY = 1'b0, ARVALID = 1'b0, RREADY = 1'b0;
    logic        AWREADY, WREADY, BVALID, ARREADY, RVALID;
    logic [1:0]  BRESP, RRESP;
    logic [31:0] RDATA;
    logic [15:0] wr_count, rd_count, err_count;

    axi4lite_ocm_responder dut (
        .ACLK(clk), .ARESET(ARESET),
        .S_AWADDR(AWADDR), .S_AWVALID(AWVALID), .S_AWREADY(AWREADY),
        .S_WDATA(WDATA), .S_WSTRB(WSTRB), .S_WVALID(WVALID), .S_WREADY(WREADY),
        .S_BRESP(BRESP), .S_BVALID(BVALID), .S_BREADY(BREADY),
        .S_ARADDR(ARADDR), .S_ARVALID(ARVALID), .S_ARREADY(ARREADY),
        .S_RDATA(RDATA), .S_RRESP(RRESP), .S_RVALID(RVALID), .S_RREADY(RREADY),
        .wr_count(wr_count), .rd_count(rd_count), .err_count(err_count)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish, got timeout, required completion");
        $fatal(1);
    end

    int checks = 0;
    int errors = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h, expected %h", nm, act, exp);
        end
    endtask

    // Reference model: plain word array plus handshake tallies.
    logic [31:0] mm [DEPTH];
    int m_wr = 0, m_rd = 0, m_err = 0;

    function automatic bit m_hit(input logic [31:0] a);
        longint ua;
        ua = {32'b0, a};
        return (ua >= BASE_L) && (ua < BASE_L + DEPTH * 4);
    endfunction

    function automatic logic [1:0] m_write(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s);
        int idx;
        if (!m_hit(a)) return 2'b10;
        idx = int'((({32'b0, a}) - BASE_L) / 4);
        for (int i = 0; i < 4; i++)
            if (s[i]) mm[idx][8*i +: 8] = d[8*i +: 8];
        return 2'b00;
    endfunction

    task automatic m_read(input logic [31:0] a, output logic [31:0] d, output logic [1:0] r);
        int idx;
        if (!m_hit(a)) begin
            d = '0;
            r = 2'b10;
        end else begin
            idx = int'((({32'b0, a}) - BASE_L) / 4);
            d = mm[idx];
            r = 2'b00;
        end
    endtask

    task automatic m_count(input bit is_wr, input logic [1:0] resp);
        if (is_wr) m_wr++; else m_rd++;
        if (resp == 2'b10) m_err++;
    endtask

    task automatic axi_write(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s,
                             input int skew, output logic [1:0] resp);
        int  aw_at, w_at, cyc, n;
        bit  aw_done, w_done, aw_hs, w_hs;
        aw_at = (skew < 0) ? -skew : 0;
        w_at  = (skew > 0) ? skew : 0;
        aw_done = 0; w_done = 0; cyc = 0; n = 0;
        BREADY = 1'b1;
        while (!(aw_done && w_done) && cyc < 40) begin
            @(negedge clk);
            AWADDR = a; WDATA = d; WSTRB = s;
            AWVALID = !aw_done && (cyc >= aw_at);
            WVALID  = !w_done && (cyc >= w_at);
            #1;
            aw_hs = AWVALID && AWREADY;
            w_hs  = WVALID && WREADY;
            @(posedge clk);
            if (aw_hs) aw_done = 1;
            if (w_hs) w_done = 1;
            cyc++;
        end
        @(negedge clk);
        AWVALID = 1'b0; WVALID = 1'b0;
        chk("wr_bvalid_latency", 32'(BVALID), 32'd1);
        while (!BVALID && n < 20) begin
            @(negedge clk);
            n++;
        end
        resp = BRESP;
        @(posedge clk);
    endtask

    task automatic axi_read(input logic [31:0] a, output logic [31:0] d, output logic [1:0] r);
        int n;
        n = 0;
        RREADY = 1'b1;
        @(negedge clk);
        ARADDR = a; ARVALID = 1'b1;
        #1;
        while (!ARREADY && n < 20) begin
            @(negedge clk);
            #1;
            n++;
        end
        @(posedge clk);
        @(negedge clk);
        ARVALID = 1'b0;
        chk("rd_rvalid_latency", 32'(RVALID), 32'd1);
        d = RDATA;
        r = RRESP;
        @(posedge clk);
    endtask

    task automatic chk_counters(input string tag);
        @(negedge clk);
        chk({tag, "_wr_count"}, 32'(wr_count), 32'(m_wr));
        chk({tag, "_rd_count"}, 32'(rd_count), 32'(m_rd));
        chk({tag, "_err_count"}, 32'(err_count), 32'(m_err));
    endtask

    typedef struct {
        bit          wr;
        logic [31:0] addr;
        logic [31:0] data;
        logic [3:0]  strb;
        logic [31:0] exp_data;
        logic [1:0]  exp_resp;
    } vec_t;

    vec_t tbl [13];

    initial begin
        logic [31:0] d, ed, a;
        logic [31:0] ra [4];
        logic [1:0]  r, er, e;
        int          sel;

        for (int i = 0; i < DEPTH; i++) mm[i] = '0;
        tbl[0]  = '{1'b1, 32'hFFFC0000, 32'hDEADBEEF, 4'hF, 32'h0,        2'b00};
        tbl[1]  = '{1'b0, 32'hFFFC0000, 32'h0,        4'h0, 32'hDEADBEEF, 2'b00};
        tbl[2]  = '{1'b1, 32'hFFFC0004, 32'h11223344, 4'hF, 32'h0,        2'b00};
        tbl[3]  = '{1'b1, 32'hFFFC0004, 32'hAABBCCDD, 4'h5, 32'h0,        2'b00};
        tbl[4]  = '{1'b0, 32'hFFFC0006, 32'h0,        4'h0, 32'h11BB33DD, 2'b00};
        tbl[5]  = '{1'b1, 32'hFFFC1000, 32'h12345678, 4'hF, 32'h0,        2'b10};
        tbl[6]  = '{1'b0, 32'hFFFC1000, 32'h0,        4'h0, 32'h0,        2'b10};
        tbl[7]  = '{1'b0, 32'hFFFC0000, 32'h0,        4'h0, 32'hDEADBEEF, 2'b00};
        tbl[8]  = '{1'b1, 32'hFFFC0FFC, 32'hCAFEF00D, 4'hF, 32'h0,        2'b00};
        tbl[9]  = '{1'b0, 32'hFFFC0FFF, 32'h0,        4'h0, 32'hCAFEF00D, 2'b00};
        tbl[10] = '{1'b0, 32'hFFFBFFFC, 32'h0,        4'h0, 32'h0,        2'b10};
        tbl[11] = '{1'b1, 32'hFFFC0008, 32'h55555555, 4'h0, 32'h0,        2'b00};
        tbl[12] = '{1'b0, 32'hFFFC0008, 32'h0,        4'h0, 32'h0,        2'b00};

        repeat (2) @(posedge clk);
        @(negedge clk);
        #1;
        chk("rst_readies", 32'({AWREADY, WREADY, ARREADY}), 32'h7);
        chk("rst_valids", 32'({BVALID, RVALID}), 32'h0);
        chk("rst_resps", 32'({BRESP, RRESP}), 32'h0);
        chk("rst_rdata", RDATA, 32'h0);
        chk("rst_wr_count", 32'(wr_count), 32'h0);
        chk("rst_err_count", 32'(err_count), 32'h0);
        ARESET = 1'b0;

        for (int i = 0; i < 13; i++) begin
            if (tbl[i].wr) begin
                axi_write(tbl[i].addr, tbl[i].data, tbl[i].strb, 0, r);
                chk($sformatf("tbl%0d_bresp", i), 32'(r), 32'(tbl[i].exp_resp));
                e = m_write(tbl[i].addr, tbl[i].data, tbl[i].strb);
                m_count(1'b1, e);
            end else begin
                axi_read(tbl[i].addr, d, r);
                chk($sformatf("tbl%0d_rdata", i), d, tbl[i].exp_data);
                chk($sformatf("tbl%0d_rresp", i), 32'(r), 32'(tbl[i].exp_resp));
                m_read(tbl[i].addr, ed, er);
                m_count(1'b0, er);
            end
        end
        chk_counters("tbl");

        // Same-cycle AW/W with B held off for five cycles.
        AWADDR = BASE + 32'h10; WDATA = 32'h0BADF00D; WSTRB = 4'hF;
        AWVALID = 1'b1; WVALID = 1'b1; BREADY = 1'b0;
        @(negedge clk);
        AWVALID = 1'b0; WVALID = 1'b0;
        e = m_write(BASE + 32'h10, 32'h0BADF00D, 4'hF);
        for (int k = 0; k < 5; k++) begin
            chk("bhold_state", 32'({BVALID, BRESP, AWREADY, WREADY}), 32'b10000);
            @(negedge clk);
        end
        BREADY = 1'b1;
        @(negedge clk);
        m_count(1'b1, e);
        chk("bdone_state", 32'({BVALID, AWREADY, WREADY}), 32'b011);

        // W three cycles ahead of AW, then AW three cycles ahead of W.
        WDATA = 32'h13572468; WSTRB = 4'hF; WVALID = 1'b1; BREADY = 1'b0;
        @(negedge clk);
        WVALID = 1'b0;
        chk("have_w_readies", 32'({AWREADY, WREADY}), 32'b10);
        repeat (2) @(negedge clk);
        AWADDR = BASE + 32'h30; AWVALID = 1'b1;
        @(negedge clk);
        AWVALID = 1'b0;
        chk("wfirst_b", 32'({BVALID, BRESP, AWREADY, WREADY}), 32'b10000);
        e = m_write(BASE + 32'h30, 32'h13572468, 4'hF);
        BREADY = 1'b1;
        @(posedge clk);
        m_count(1'b1, e);
        axi_write(BASE + 32'h34, 32'h24681357, 4'hF, 3, r);
        chk("awfirst_bresp", 32'(r), 32'h0);
        e = m_write(BASE + 32'h34, 32'h24681357, 4'hF);
        m_count(1'b1, e);
        axi_read(BASE + 32'h30, d, r);
        chk("wfirst_readback", d, 32'h13572468);
        m_count(1'b0, 2'b00);
        axi_read(BASE + 32'h34, d, r);
        chk("awfirst_readback", d, 32'h24681357);
        m_count(1'b0, 2'b00);

        // Back-to-back reads, then a four-cycle R stall.
        ra[0] = BASE; ra[1] = BASE + 32'h4; ra[2] = BASE + 32'h10; ra[3] = BASE + 32'hFFC;
        @(negedge clk);
        RREADY = 1'b1; ARADDR = ra[0]; ARVALID = 1'b1;
        #1;
        chk("b2b_arready0", 32'(ARREADY), 32'd1);
        for (int k = 1; k <= 4; k++) begin
            @(negedge clk);
            m_read(ra[k-1], ed, er);
            chk($sformatf("b2b_rvalid%0d", k), 32'(RVALID), 32'd1);
            chk($sformatf("b2b_rdata%0d", k), RDATA, ed);
            if (k < 4) begin
                m_count(1'b0, er);
                ARADDR = ra[k];
                #1;
                chk($sformatf("b2b_arready%0d", k), 32'(ARREADY), 32'd1);
            end
        end
        ARVALID = 1'b0; RREADY = 1'b0;
        #1;
        for (int k = 0; k < 4; k++) begin
            chk("rstall_state", 32'({RVALID, ARREADY}), 32'b10);
            chk("rstall_rdata", RDATA, ed);
            @(negedge clk);
            #1;
        end
        RREADY = 1'b1;
        @(negedge clk);
        m_count(1'b0, er);
        chk("rstall_release", 32'(RVALID), 32'd0);

        // Write and read of the same word in the same cycle; then both out of range.
        axi_write(BASE + 32'h20, 32'h01020304, 4'hF, 0, r);
        e = m_write(BASE + 32'h20, 32'h01020304, 4'hF);
        m_count(1'b1, e);
        for (int k = 0; k < 2; k++) begin
            a = (k == 0) ? BASE + 32'h20 : BASE + 32'h1000;
            @(negedge clk);
            AWADDR = a; ARADDR = a; WDATA = 32'hA0B0C0D0; WSTRB = 4'b1010;
            AWVALID = 1'b1; WVALID = 1'b1; ARVALID = 1'b1; BREADY = 1'b1; RREADY = 1'b1;
            @(negedge clk);
            AWVALID = 1'b0; WVALID = 1'b0; ARVALID = 1'b0;
            e = m_write(a, 32'hA0B0C0D0, 4'b1010);
            m_read(a, ed, er);
            chk($sformatf("conc%0d_valids", k), 32'({BVALID, RVALID}), 32'b11);
            chk($sformatf("conc%0d_rdata", k), RDATA, ed);
            chk($sformatf("conc%0d_resps", k), 32'({BRESP, RRESP}), 32'({e, er}));
            m_count(1'b1, e);
            m_count(1'b0, er);
        end
        chk("conc_wbr_value", ed, 32'h0);
        chk_counters("conc");

        for (int i = 0; i < 250; i++) begin
            sel = int'($urandom_range(0, 9));
            if (sel == 0)      a = BASE + 32'h1000 + ($urandom_range(0, 63) << 2);
            else if (sel == 1) a = BASE - 32'd4 - ($urandom_range(0, 63) << 2);
            else if (sel == 2) a = BASE + ((32'd1023 - $urandom_range(0, 3)) << 2) + $urandom_range(0, 3);
            else               a = BASE + ($urandom_range(0, 31) << 2) + $urandom_range(0, 3);
            if ($urandom_range(0, 1) == 1) begin
                d = $urandom;
                WSTRB = 4'($urandom_range(0, 15));
                e = m_write(a, d, WSTRB);
                axi_write(a, d, WSTRB, int'($urandom_range(0, 6)) - 3, r);
                chk($sformatf("rand%0d_bresp", i), 32'(r), 32'(e));
                m_count(1'b1, e);
            end else begin
                axi_read(a, d, r);
                m_read(a, ed, er);
                chk($sformatf("rand%0d_rdata", i), d, ed);
                chk($sformatf("rand%0d_rresp", i), 32'(r), 32'(er));
                m_count(1'b0, er);
            end
        end
        chk_counters("rand");

        // Reset while a B response is pending.
        @(negedge clk);
        AWADDR = BASE + 32'h40; WDATA = 32'h99999999; WSTRB = 4'hF;
        AWVALID = 1'b1; WVALID = 1'b1; BREADY = 1'b0;
        @(negedge clk);
        AWVALID = 1'b0; WVALID = 1'b0;
        e = m_write(BASE + 32'h40, 32'h99999999, 4'hF);
        chk("pre_reset_bvalid", 32'(BVALID), 32'd1);
        ARESET = 1'b1;
        @(negedge clk);
        ARESET = 1'b0;
        m_wr = 0; m_rd = 0; m_err = 0;
        chk("post_reset_state", 32'({BVALID, AWREADY, WREADY, RVALID}), 32'b0110);
        chk("post_reset_rdata", RDATA, 32'h0);
        chk("post_reset_wr_count", 32'(wr_count), 32'h0);
        chk("post_reset_rd_count", 32'(rd_count), 32'h0);
        chk("post_reset_err_count", 32'(err_count), 32'h0);
        axi_read(BASE + 32'h40, d, r);
        chk("post_reset_readback", d, 32'h99999999);
        m_count(1'b0, r);

        // A commit edge coinciding with reset must not write.
        @(negedge clk);
        AWADDR = BASE + 32'h44; WDATA = 32'h77777777; WSTRB = 4'hF;
        AWVALID = 1'b1; WVALID = 1'b1; BREADY = 1'b0; ARESET = 1'b1;
        @(negedge clk);
        AWVALID = 1'b0; WVALID = 1'b0; ARESET = 1'b0;
        m_wr = 0; m_rd = 0; m_err = 0;
        chk("rst_commit_bvalid", 32'(BVALID), 32'd0);
        axi_read(BASE + 32'h44, d, r);
        m_read(BASE + 32'h44, ed, er);
        chk("rst_commit_suppressed", d, ed);
        m_count(1'b0, er);
        chk_counters("final");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
